// File: rtl/ring_local_port_if.sv
// Handshake bundle between ring_local_port and its NIC / ring crossbar neighbours.
// master = the router-side local port, slave = the NIC plus ring crossbar side.
interface ring_local_port_if #(
  parameter int PACKET_SIZE = 64
);
  logic                   nic_so;
  logic                   nic_ro;
  logic [PACKET_SIZE-1:0] nic_do;
  logic                   nic_si;
  logic                   nic_ri;
  logic [PACKET_SIZE-1:0] nic_di;
  logic                   inj_so;
  logic                   inj_ro;
  logic [PACKET_SIZE-1:0] inj_do;
  logic                   ej_si;
  logic                   ej_ri;
  logic [PACKET_SIZE-1:0] ej_di;

  modport master (
    input  nic_so, nic_do, nic_ri, inj_ro, ej_si, ej_di,
    output nic_ro, nic_si, nic_di, inj_so, inj_do, ej_ri
  );

  modport slave (
    output nic_so, nic_do, nic_ri, inj_ro, ej_si, ej_di,
    input  nic_ro, nic_si, nic_di, inj_so, inj_do, ej_ri
  );
endinterface

// File: rtl/ring_local_port.sv
// Router-side NIC endpoint: two polarity-scheduled 1-entry VC buffers per direction.
// Optional VC checking (drop mismatched packets, sticky vc_err) under LOCAL_PORT_VCCHK_EN.
module ring_local_port #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  output logic                polarity,
  output logic                vc_err,
  ring_local_port_if.master   port
);

  logic [PACKET_SIZE-1:0] ib [2];
  logic [PACKET_SIZE-1:0] eb [2];
  logic [1:0]             ib_full;
  logic [1:0]             eb_full;
  logic                   opp;
  logic                   nic_cap;
  logic                   inj_take;
  logic                   ej_cap;
  logic                   nic_take;
  logic                   nic_keep;
  logic                   ej_keep;

  // NIC side serves VC = polarity, ring side serves VC = ~polarity.
  assign opp         = ~polarity;
  assign port.nic_ro = ~ib_full[polarity];
  assign port.inj_so = ib_full[opp];
  assign port.inj_do = ib[opp];
  assign port.ej_ri  = ~eb_full[opp];
  assign port.nic_si = eb_full[polarity] & port.nic_ri;
  assign port.nic_di = eb[polarity];

  assign nic_cap  = port.nic_so & port.nic_ro;
  assign inj_take = port.inj_so & port.inj_ro;
  assign ej_cap   = port.ej_si & port.ej_ri;
  assign nic_take = port.nic_si;

`ifdef LOCAL_PORT_VCCHK_EN
  // A mismatched packet still completes its handshake but is never stored.
  assign nic_keep = (port.nic_do[0] == polarity);
  assign ej_keep  = (port.ej_di[0] == opp);

  always_ff @(posedge clk) begin
    if (reset) begin
      vc_err <= 1'b0;
    end else if ((nic_cap & ~nic_keep) | (ej_cap & ~ej_keep)) begin
      vc_err <= 1'b1;
    end
  end
`else
  assign nic_keep = 1'b1;
  assign ej_keep  = 1'b1;
  assign vc_err   = 1'b0;
`endif

  // Write and free always target opposite buffer indices within one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity <= 1'b0;
      ib_full  <= 2'b00;
      eb_full  <= 2'b00;
      ib[0]    <= '0;
      ib[1]    <= '0;
      eb[0]    <= '0;
      eb[1]    <= '0;
    end else begin
      polarity <= ~polarity;
      if (nic_cap & nic_keep) begin
        ib[polarity]      <= port.nic_do;
        ib_full[polarity] <= 1'b1;
      end
      if (inj_take) begin
        ib_full[opp] <= 1'b0;
      end
      if (ej_cap & ej_keep) begin
        eb[opp]      <= port.ej_di;
        eb_full[opp] <= 1'b1;
      end
      if (nic_take) begin
        eb_full[polarity] <= 1'b0;
      end
    end
  end

endmodule
